// File: rtl/bus_io_responder.sv
// bus_io_responder
// I/O-space responder for the CFT 2019 expansion bus. Decodes I/O cycles
// aimed at a four-word window. Stretches each cycle with a programmable
// number of wait states on open-drain nws, and serves four registers:
//   0 DATA    word FIFO mailbox (write pushes, read pops)
//   1 STATUS  {10'b0, ovf, count[2:0], full, empty}; read clears ovf,
//             write with bit15 set flushes the FIFO
//   2 CTRL    bit0 = interrupt enable, bits 15:1 scratch
//   3 IDENT   read-only 16'hCF19
// Interrupt request on open-drain nirq = IE & FIFO not empty (registered).
//
// Ports:
//   clk1     system clock, rising edge
//   nreset   asynchronous active-low reset
//   ab       24-bit address bus (only ab[9:0] decoded)
//   db_in    sampled data bus
//   db_out   registered read data
//   db_oe    enable for driving db_out onto the data bus
//   nio      I/O space strobe, active low
//   nr, nw   read / write strobes, active low
//   nws_oe   1 = pull nws low (wait request)
//   nirq_oe  1 = pull nirq low (interrupt request)

module bus_io_responder #(
  parameter logic [9:0] BASE_ADDR   = 10'h100,
  parameter int         WAIT_STATES = 2,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic        clk1,
  input  logic        nreset,
  input  logic [23:0] ab,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  input  logic        nio,
  input  logic        nr,
  input  logic        nw,
  output logic        nws_oe,
  output logic        nirq_oe
);

  localparam int              PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]   COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [2:0]      CNT_INIT   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [15:0]     IDENT      = 16'hCF19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      cnt, cnt_nx;
  logic            rd_cyc;
  logic            sel;
  logic            enter_access;
  logic            read_req;
  logic            read_commit;
  logic            write_commit;
  logic [1:0]      idx;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [15:0]     ctrl;
  logic            empty, full;
  logic [3:0]      count_ext;
  logic [15:0]     status;
  logic [15:0]     rd_mux;
  logic            do_push, do_pop, do_flush, push_drop;
  logic            unused_bits;

  // A cycle with both strobes low is a protocol error and never selects.
  assign sel = ~nio & (nr ^ nw) & (ab[9:2] == BASE_ADDR[9:2]);
  assign idx = ab[1:0];

  assign unused_bits = ^{ab[23:10], count_ext[3]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      state  <= ST_IDLE;
      cnt    <= 3'd0;
      rd_cyc <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_IDLE && sel)
        rd_cyc <= ~nr;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    enter_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel) begin
          if (WAIT_STATES == 0) begin
            state_nx     = ST_ACCESS;
            enter_access = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Losing sel while waiting aborts the cycle with no side effect.
        if (!sel) begin
          state_nx = ST_IDLE;
        end else if (cnt == 3'd0) begin
          state_nx     = ST_ACCESS;
          enter_access = 1'b1;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      ST_ACCESS: begin
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        // Hold here until the initiator ends the cycle so a lingering
        // strobe cannot trigger a second side effect.
        if (nio || (nr && nw))
          state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Direction comes straight from the strobes on the zero-wait IDLE edge,
  // otherwise from the direction latched when the cycle was first seen.
  assign read_req     = (state == ST_IDLE) ? ~nr : rd_cyc;
  assign read_commit  = enter_access & read_req;
  assign write_commit = (state == ST_ACCESS) & ~rd_cyc;

  assign nws_oe = (state == ST_WAIT);
  assign db_oe  = rd_cyc & ((state == ST_ACCESS) | ((state == ST_DONE) & ~nr));

  assign empty     = (count == '0);
  assign full      = (count == COUNT_FULL);
  assign count_ext = 4'(count);
  assign status    = {10'b0, ovf, count_ext[2:0], full, empty};

  always_comb begin
    rd_mux = 16'h0000;
    case (idx)
      2'd0:    rd_mux = empty ? 16'h0000 : mem[rd_ptr];
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = ctrl;
      default: rd_mux = IDENT;
    endcase
  end

  assign do_pop    = read_commit  & (idx == 2'd0) & ~empty;
  assign do_push   = write_commit & (idx == 2'd0) & ~full;
  assign push_drop = write_commit & (idx == 2'd0) & full;
  assign do_flush  = write_commit & (idx == 2'd1) & db_in[15];

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk1) begin
    if (do_push)
      mem[wr_ptr] <= db_in;
  end

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      ctrl    <= 16'h0000;
      db_out  <= 16'h0000;
      nirq_oe <= 1'b0;
    end else begin
      // Push (ACCESS edge) and pop (entry into ACCESS) never coincide.
      if (do_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        count  <= count + CW'(1);
      end else if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        count  <= count - CW'(1);
      end

      if (push_drop)
        ovf <= 1'b1;
      else if (read_commit && idx == 2'd1)
        ovf <= 1'b0;

      if (write_commit && idx == 2'd2)
        ctrl <= db_in;

      if (read_commit)
        db_out <= rd_mux;

      nirq_oe <= ctrl[0] & ~empty;
    end
  end

endmodule
